// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses, mstatus/mie bit positions and interrupt cause codes.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MSI      = 3;
  localparam int IRQ_MTI      = 7;
  localparam int IRQ_MEI      = 11;

  localparam logic [31:0] IRQ_MASK  = 32'h0000_0888;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
endpackage

// File: rtl/csr_if.sv
// Software CSR access port: decoder (master) drives address/write, CSR file (slave) returns data.
interface csr_if #(parameter int XLEN = 32);
  logic            we;
  logic [11:0]     a;
  logic [XLEN-1:0] di;
  logic [XLEN-1:0] dOut;
  logic            illegal;

  modport master (output we, a, di, input dOut, illegal);
  modport slave  (input we, a, di, output dOut, illegal);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free counter with independently writable 32-bit halves.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        weLo,
  input  logic        weHi,
  input  logic [31:0] di,
  output logic [63:0] value
);
  // A software write to either half suppresses the increment for the whole counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (weLo || weHi) begin
      if (weLo) value[31:0]  <= di;
      if (weHi) value[63:32] <= di;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap/mret state, interrupt gating, vectored mtvec, 64-bit counters.
module csr_file
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  csr_if.slave            bus,
  input  logic            trap,
  input  logic [XLEN-1:0] trapPc,
  input  logic [XLEN-1:0] trapCause,
  input  logic            mret,
  input  logic            retire,
  input  logic            irqExt,
  input  logic            irqTimer,
  input  logic            irqSoft,
  output logic [XLEN-1:0] mepcDo,
  output logic [XLEN-1:0] mtvecDo,
  output logic [XLEN-1:0] mcauseDo,
  output logic [XLEN-1:0] trapVector,
  output logic            irqPending,
  output logic [XLEN-1:0] irqCause
);
  logic            mstMie, mstMpie;
  logic [XLEN-1:0] mieReg, mipReg, mtvec, mscratch, mepc, mcause;
  logic [XLEN-1:0] mstatusRd, irqLines, pend;
  logic [63:0]     mcycle, minstret;
  logic            impl, ro, swWe;

  // Decode the read address; flags unimplemented and read-only CSRs.
  always_comb begin
    bus.dOut = '0;
    impl     = 1'b1;
    ro       = 1'b0;
    case (bus.a)
      CSR_MSTATUS:   bus.dOut = mstatusRd;
      CSR_MISA:      begin bus.dOut = MISA_VAL; ro = 1'b1; end
      CSR_MHARTID:   begin bus.dOut = HART_ID;  ro = 1'b1; end
      CSR_MIE:       bus.dOut = mieReg;
      CSR_MIP:       begin bus.dOut = mipReg; ro = 1'b1; end
      CSR_MTVEC:     bus.dOut = mtvec;
      CSR_MSCRATCH:  bus.dOut = mscratch;
      CSR_MEPC:      bus.dOut = mepc;
      CSR_MCAUSE:    bus.dOut = mcause;
      CSR_MCYCLE:    bus.dOut = mcycle[31:0];
      CSR_MCYCLEH:   bus.dOut = mcycle[63:32];
      CSR_MINSTRET:  bus.dOut = minstret[31:0];
      CSR_MINSTRETH: bus.dOut = minstret[63:32];
      CSR_CYCLE:     begin bus.dOut = mcycle[31:0];    ro = 1'b1; end
      CSR_CYCLEH:    begin bus.dOut = mcycle[63:32];   ro = 1'b1; end
      CSR_INSTRET:   begin bus.dOut = minstret[31:0];  ro = 1'b1; end
      CSR_INSTRETH:  begin bus.dOut = minstret[63:32]; ro = 1'b1; end
      default:       impl = 1'b0;
    endcase
  end

  assign bus.illegal = !impl || (bus.we && ro);
  assign swWe        = bus.we && impl && !ro;

  // mstatus view: MPP hardwired to machine mode.
  always_comb begin
    mstatusRd               = '0;
    mstatusRd[12:11]        = 2'b11;
    mstatusRd[MSTATUS_MIE]  = mstMie;
    mstatusRd[MSTATUS_MPIE] = mstMpie;
  end

  // Trap/mret/software updates; trap beats mret beats software on mstatus/mepc/mcause.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstMie   <= 1'b0;
      mstMpie  <= 1'b0;
      mieReg   <= '0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else begin
      if (trap) begin
        mepc    <= {trapPc[XLEN-1:2], 2'b00};
        mcause  <= trapCause;
        mstMpie <= mstMie;
        mstMie  <= 1'b0;
      end else if (mret) begin
        mstMie  <= mstMpie;
        mstMpie <= 1'b1;
      end else if (swWe) begin
        if (bus.a == CSR_MSTATUS) begin
          mstMie  <= bus.di[MSTATUS_MIE];
          mstMpie <= bus.di[MSTATUS_MPIE];
        end
        if (bus.a == CSR_MEPC)   mepc   <= {bus.di[XLEN-1:2], 2'b00};
        if (bus.a == CSR_MCAUSE) mcause <= bus.di;
      end
      if (swWe && bus.a == CSR_MIE)      mieReg   <= bus.di & IRQ_MASK;
      if (swWe && bus.a == CSR_MSCRATCH) mscratch <= bus.di;
      if (swWe && bus.a == CSR_MTVEC && !bus.di[1]) mtvec <= bus.di;
    end
  end

  always_comb begin
    irqLines          = '0;
    irqLines[IRQ_MEI] = irqExt;
    irqLines[IRQ_MTI] = irqTimer;
    irqLines[IRQ_MSI] = irqSoft;
  end

  // mip registers the level inputs, giving one cycle of latency to irqPending.
  always_ff @(posedge clk) begin
    if (reset) mipReg <= '0;
    else       mipReg <= irqLines;
  end

  assign pend       = mipReg & mieReg;
  assign irqPending = mstMie && (|pend);
  assign irqCause   = pend[IRQ_MEI] ? CAUSE_MEI :
                      pend[IRQ_MSI] ? CAUSE_MSI :
                      pend[IRQ_MTI] ? CAUSE_MTI : '0;

  // Vectored mode offsets interrupts by 4*cause; exceptions always go to base.
  assign trapVector = (mtvec[1:0] == 2'b01 && trapCause[XLEN-1])
                    ? {mtvec[XLEN-1:2], 2'b00} + {trapCause[XLEN-3:0], 2'b00}
                    : {mtvec[XLEN-1:2], 2'b00};

  assign mepcDo   = mepc;
  assign mtvecDo  = mtvec;
  assign mcauseDo = mcause;

  csr_counter64 uCycle (
    .clk(clk), .reset(reset), .inc(1'b1),
    .weLo(swWe && bus.a == CSR_MCYCLE), .weHi(swWe && bus.a == CSR_MCYCLEH),
    .di(bus.di), .value(mcycle)
  );

  csr_counter64 uInstret (
    .clk(clk), .reset(reset), .inc(retire),
    .weLo(swWe && bus.a == CSR_MINSTRET), .weHi(swWe && bus.a == CSR_MINSTRETH),
    .di(bus.di), .value(minstret)
  );
endmodule
